// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and width-derived constants for the multiply/divide unit.
package muldiv_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide producing MIPS HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CW = cnt_w(WIDTH);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, rneg_q, rneg_d, busy_q, busy_d, done_q, done_d;
  logic sgn, sa, sb, dz;
  logic [WIDTH:0] add_s, sub_s;
  logic [2*WIDTH:0] sh;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;
  always_comb begin
    sgn = (op == OP_MULT) || (op == OP_DIV);
    dz = op[1] && (rt_data == '0);
    sa = sgn && rs_data[WIDTH-1] && !dz;
    sb = sgn && rt_data[WIDTH-1];
    add_s = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    sh = {p_q, 1'b0};
    sub_s = sh[2*WIDTH:WIDTH] - {1'b0, b_q};
    prod = neg_q ? -p_q : p_q;
    quo = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    op_d = op_q;
    p_d = p_q;
    b_d = b_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // A zero divisor keeps the raw dividend unsigned so HI ends up equal to rs_data.
          op_d = op_e'(op);
          p_d = {{WIDTH{1'b0}}, sa ? -rs_data : rs_data};
          b_d = sb ? -rt_data : rt_data;
          neg_d = sa ^ (sb && !dz);
          rneg_d = sa;
          cnt_d = '0;
          state_d = CALC;
        end else begin
          hi_d = mthi ? rs_data : hi_q;
          lo_d = mtlo ? rs_data : lo_q;
        end
      end
      CALC: begin
        p_d = !op_q[1] ? {add_s, p_q[WIDTH-1:1]}
            : !sub_s[WIDTH] ? {sub_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1}
            : sh[2*WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : CALC;
      end
      FIX: begin
        hi_d = op_q[1] ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d = op_q[1] ? quo : prod[WIDTH-1:0];
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= OP_MULT;
      p_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      p_q <= p_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard queue checked by a done-driven monitor.
module tb_muldiv_unit;
  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] op = 2'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic mthi = 1'b0;
  logic mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic busy, done;
  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_hi", hi, e.h);
        check("result_lo", lo, e.l);
        check("busy_cycles", 32'(busy_cnt), 32'd33);
      end
      busy_cnt = 0;
    end else if (busy) busy_cnt++;
    else busy_cnt = 0;
  end
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    @(negedge clk);
    op = o;
    rs_data = a;
    rt_data = b;
    start = 1'b1;
    if (push) sb_q.push_back('{h: eh, l: el});
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL timeout: busy still %0d after %0d cycles expected 0", busy, n);
    end
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1);
    wait_idle();
    issue(2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1);
    wait_idle();
    issue(2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1);
    wait_idle();
    issue(2'd3, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1);
    wait_idle();
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1);
    wait_idle();
    issue(2'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1);
    wait_idle();
    issue(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1);
    repeat (9) @(negedge clk);
    op = 2'd1;
    rs_data = 32'd5;
    rt_data = 32'd5;
    start = 1'b1;
    mthi = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mthi = 1'b0;
    check("busy_hold_hi", hi, 32'hFFFFFFF9);
    check("busy_hold_lo", lo, 32'hFFFFFFFF);
    wait_idle();
    issue(2'd0, 32'd1234, 32'd5678, 32'd0, 32'd0, 0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    issue(2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1);
    wait_idle();
    @(negedge clk);
    rs_data = 32'hAAAA5555;
    mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'hAAAA5555);
    check("mthi_lo", lo, 32'd12);
    check("mthi_done", 32'(done), 32'h0);
    check("mthi_busy", 32'(busy), 32'h0);
    @(negedge clk);
    op = 2'd1;
    rs_data = 32'h10;
    rt_data = 32'h10;
    start = 1'b1;
    mtlo = 1'b1;
    sb_q.push_back('{h: 32'h0, l: 32'h100});
    @(negedge clk);
    start = 1'b0;
    mtlo = 1'b0;
    check("start_wins_lo", lo, 32'd12);
    check("start_wins_busy", 32'(busy), 32'h1);
    wait_idle();
    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the multicycle MIPS datapath. Sits directly downstream of the register file.
- Consumes the registered rs/rt read data and produces the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- The controller FSM issues start and stalls on busy.
- HI/LO outputs feed the writeback mux for MFHI/MFLO.

Parameters:
WIDTH, 32, operand/result width; shift/iteration count equals WIDTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin operation with op/rs_data/rt_data sampled this edge
op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
rs_data  in  WIDTH  operand A (multiplicand / dividend)
rt_data  in  WIDTH  operand B (multiplier / divisor)
mthi  in  1  write rs_data to HI
mtlo  in  1  write rs_data to LO
hi  out  WIDTH  HI register (product upper / remainder)
lo  out  WIDTH  LO register (product lower / quotient)
busy  out  1  operation in progress; new start/mthi/mtlo ignored
done  out  1  single-cycle pulse: HI/LO just updated by mul/div

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE.
- Reset mid-operation aborts immediately to IDLE with the same values.
- States:
  - IDLE: on edge E0 with start=1, capture op, the operand magnitudes, the result signs and a divide-by-zero flag. Clear the iteration counter. Go to CALC.
  - CALC: one shift-add (mul) or restoring shift-subtract (div) iteration per edge, 32 iterations on edges E1..E32. After the 32nd, go to FIX.
  - FIX: on edge E33, apply the sign fix and write hi/lo. Set done=1 for the following cycle. Go to IDLE.
- Latency: busy=1 in the cycles after E0 through E33 (33 cycles). done and the new hi/lo are visible in the cycle after E33.
- Fixed latency for every op, including divide-by-zero.
- Signed ops (MULT/DIV):
  - Operate on magnitudes (two's-complement negate if the MSB is set).
  - Product sign = signA^signB; negate the full 2*WIDTH product.
  - Quotient sign = signA^signB; remainder sign = signA.
- Unsigned ops use raw operands.
- MUL result: hi = product[63:32], lo = product[31:0].
- DIV result: lo = quotient, hi = remainder.
- Divide by zero (rt_data==0 at E0), both DIV and DIVU: lo=32'hFFFF_FFFF, hi=rs_data as captured. No exception.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of 32-bit wrap on negation and must not be trapped.
- mthi/mtlo in IDLE with start=0: hi (resp. lo) <= rs_data on that edge. Both asserted together writes both.
- Simultaneous start and mthi/mtlo in IDLE: start wins; moves are ignored.
- start, mthi and mtlo while busy=1 are ignored. Operands and op are held internally, so input changes during CALC have no effect.
- hi/lo hold their values throughout CALC. Intermediate state lives in internal accumulators only.
- done is 0 except for the single cycle after FIX. mthi/mtlo never raise done.

Decomposition:
- Shared package muldiv_pkg: op enum (MULT, MULTU, DIV, DIVU), state enum (IDLE, CALC, FIX), WIDTH-derived constants (counter width = $clog2(WIDTH)+1).
- No sub-module. The iteration core, sign handling and HI/LO registers fit in one module. The controller imports the op enum from the same package.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 33 busy cycles: done pulse, hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=0x12345678, rt=0 -> same 33-cycle latency, lo=0xFFFFFFFF, hi=0x12345678. Also DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU 100/7; pulse start (MULTU) and mthi=1 at cycle 10 of busy -> both ignored; result lo=14, hi=2, unchanged operand behaviour.
- Start MULT; assert rst at cycle 20 -> next cycle hi=lo=0, busy=0, done=0. A following start runs a full 33 cycles.
- IDLE: mthi rs=0xAAAA5555 -> hi=0xAAAA5555, done stays 0. mtlo and start together -> start taken, lo not written by the move.
